// File: rtl/floppy_step_ctrl.sv
`default_nettype none
// floppy_step_ctrl: STEP/DIR sequencer for one floppy voice, reversing at the track limits.
// Rev 1.0. Optional homing sequence (reset and home_req) enabled by defining FLOPPY_HOME_EN.
module floppy_step_ctrl #(
  parameter int SP_W        = 22,
  parameter int MAX_TRACK   = 79,
  parameter int PULSE_CLKS  = 50,
  parameter int HOME_PERIOD = 150000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SP_W-1:0] setpoint,
  input  logic            enable,
  input  logic            home_req,
  output logic            step,
  output logic            dir,
  output logic [6:0]      track,
  output logic            homing
);

  localparam int HP_W  = $clog2(HOME_PERIOD + 1);
  localparam int CNT_W = (SP_W > HP_W) ? SP_W : HP_W;

  localparam logic [CNT_W-1:0] MIN_PER   = CNT_W'(2 * PULSE_CLKS);
  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CLKS - 1);
  localparam logic [6:0]       TOP       = 7'(MAX_TRACK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PULSE = 2'd2
`ifdef FLOPPY_HOME_EN
    , S_HOME = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [6:0]       track_q, track_d;
  logic             dir_q, dir_d;

  logic [CNT_W-1:0] w_sp_ext;
  logic [CNT_W-1:0] w_per_last;
  logic             w_play_ok;
  logic [6:0]       w_next_track;

  assign w_sp_ext     = CNT_W'(sp_q);
  assign w_per_last   = ((w_sp_ext > MIN_PER) ? w_sp_ext : MIN_PER) - CNT_W'(1);
  assign w_play_ok    = enable && (setpoint != '0);
  assign w_next_track = dir_q ? (track_q + 7'd1) : (track_q - 7'd1);

`ifdef FLOPPY_HOME_EN
  localparam logic [CNT_W-1:0] HOME_LAST    = CNT_W'(HOME_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOME_STEP_ON = CNT_W'(HOME_PERIOD - PULSE_CLKS);

  logic [6:0] hcnt_q, hcnt_d;
  logic       hpend_q, hpend_d;
  logic       w_go_home;
`else
  logic unused_home_req;
  assign unused_home_req = home_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    track_d = track_q;
    dir_d   = dir_q;
`ifdef FLOPPY_HOME_EN
    hcnt_d    = hcnt_q;
    hpend_d   = hpend_q;
    w_go_home = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef FLOPPY_HOME_EN
        if (home_req) begin
          w_go_home = 1'b1;
        end else
`endif
        if (w_play_ok) begin
          state_d = S_PLAY;
          sp_d    = setpoint;
        end
      end
      S_PLAY: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef FLOPPY_HOME_EN
        if (home_req) begin
          w_go_home = 1'b1;
        end else
`endif
        if (!w_play_ok) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == w_per_last) begin
          // Period boundary: the only point where a new setpoint is taken.
          state_d = S_PULSE;
          cnt_d   = '0;
          sp_d    = setpoint;
          track_d = w_next_track;
          if (w_next_track == TOP) begin
            dir_d = 1'b0;
          end else if (w_next_track == 7'd0) begin
            dir_d = 1'b1;
          end
        end
      end
      S_PULSE: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef FLOPPY_HOME_EN
        if (home_req) begin
          hpend_d = 1'b1;
        end
`endif
        if (cnt_q == PULSE_END) begin
`ifdef FLOPPY_HOME_EN
          if (hpend_q || home_req) begin
            w_go_home = 1'b1;
          end else
`endif
          if (!w_play_ok) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_PLAY;
          end
        end
      end
`ifdef FLOPPY_HOME_EN
      S_HOME: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HOME_LAST) begin
          cnt_d = '0;
          if (hcnt_q == TOP) begin
            state_d = S_IDLE;
            dir_d   = 1'b1;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 7'd1;
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef FLOPPY_HOME_EN
    if (w_go_home) begin
      state_d = S_HOME;
      cnt_d   = '0;
      track_d = '0;
      dir_d   = 1'b0;
      hcnt_d  = '0;
      hpend_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef FLOPPY_HOME_EN
      state_q <= S_HOME;
      dir_q   <= 1'b0;
`else
      state_q <= S_IDLE;
      dir_q   <= 1'b1;
`endif
      cnt_q   <= '0;
      sp_q    <= '0;
      track_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      track_q <= track_d;
    end
  end

`ifdef FLOPPY_HOME_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      hpend_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      hpend_q <= hpend_d;
    end
  end
`endif

  // Outputs decode straight from state, so an async reset drops step at once.
  always_comb begin
    step   = (state_q == S_PULSE);
    homing = 1'b0;
`ifdef FLOPPY_HOME_EN
    if ((state_q == S_HOME) && (cnt_q >= HOME_STEP_ON)) begin
      step = 1'b1;
    end
    homing = (state_q == S_HOME);
`endif
  end

  assign dir   = dir_q;
  assign track = track_q;

endmodule
`default_nettype wire

// File: tb/tb_floppy_step_ctrl.sv
`default_nettype none
// tb_floppy_step_ctrl: stimulus queues expected STEP pulses; a negedge monitor pops and checks them.
module tb_floppy_step_ctrl;

  localparam int SP_W = 22;
  localparam int MAXT = 3;
  localparam int PW   = 50;
  localparam int HP   = 200;

  localparam int OFFS [12] = '{201, 401, 601, 801, 1001, 1201, 1401, 1801, 2201, 2301, 2401, 2501};
  localparam int TRKS [12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
  localparam int DIRS [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};

  logic            clk;
  logic            rst_n;
  logic [SP_W-1:0] setpoint;
  logic            enable;
  logic            home_req;
  logic            step;
  logic            dir;
  logic [6:0]      track;
  logic            homing;

  int cyc;
  int n_cmp;
  int n_bad;

  typedef struct {
    int rise;
    int trk;
    int dr;
    int width;
  } exp_t;
  exp_t q[$];

  floppy_step_ctrl #(
    .SP_W(SP_W), .MAX_TRACK(MAXT), .PULSE_CLKS(PW), .HOME_PERIOD(HP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .setpoint(setpoint), .enable(enable), .home_req(home_req),
    .step(step), .dir(dir), .track(track), .homing(homing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int rise, input int trk, input int dr, input int width);
    exp_t e;
    e.rise  = rise;
    e.trk   = trk;
    e.dr    = dr;
    e.width = width;
    q.push_back(e);
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: rising STEP pops an expectation; falling STEP checks its width.
  initial begin : monitor
    bit   prev_step;
    bit   in_pulse;
    int   rise_cyc;
    int   exp_w;
    exp_t e;
    prev_step = 1'b0;
    in_pulse  = 1'b0;
    rise_cyc  = 0;
    exp_w     = 0;
    forever begin
      @(negedge clk);
      if (step && !prev_step && !homing) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_step: got step rise at cycle %0d, required none", cyc);
        end else begin
          e = q.pop_front();
          chk("rise_cycle", cyc, e.rise);
          chk("track", int'(track), e.trk);
          chk("dir", int'(dir), e.dr);
          rise_cyc = cyc;
          exp_w    = e.width;
          in_pulse = 1'b1;
        end
      end
      if (!step && in_pulse) begin
        chk("step_width", cyc - rise_cyc, exp_w);
        in_pulse = 1'b0;
      end
      prev_step = step;
    end
  end

  initial begin : stim
    int t0;
    int t1;
    int t2;
    int lim;
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    setpoint = '0;
    enable   = 1'b0;
    home_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef FLOPPY_HOME_EN
    chk("rst_homing", int'(homing), 1);
    chk("rst_dir", int'(dir), 0);
`else
    chk("rst_homing", int'(homing), 0);
    chk("rst_dir", int'(dir), 1);
`endif
    chk("rst_step", int'(step), 0);
    chk("rst_track", int'(track), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef FLOPPY_HOME_EN
    lim = cyc + (MAXT + 1) * HP + 50;
    while (homing && (cyc < lim)) begin
      @(posedge clk);
      #1;
    end
    chk("home_done", int'(homing), 0);
    chk("home_dir", int'(dir), 1);
    chk("home_track", int'(track), 0);
`endif

    // Bounce between the limits; period 200 -> 400 -> clamped 100.
    go(cyc + 5);
    t0 = cyc;
    for (int i = 0; i < 12; i++) push(t0 + OFFS[i], TRKS[i], DIRS[i], PW);
    setpoint = 22'd200;
    enable   = 1'b1;
    go(t0 + 1301);
    setpoint = 22'd400;
    go(t0 + 1901);
    setpoint = 22'd30;
    // Drop enable on the 10th cycle of the last pulse.
    go(t0 + 2510);
    enable = 1'b0;

    // Enable dropped mid-PLAY: one pulse only.
    t1 = t0 + 2700;
    go(t1);
    push(t1 + 201, 1, 1, PW);
    setpoint = 22'd200;
    enable   = 1'b1;
    go(t1 + 301);
    enable = 1'b0;

    // home_req while playing, then reset in the middle of a pulse.
    t2 = t1 + 800;
    go(t2);
    push(t2 + 201, 2, 1, PW);
    push(t2 + 401, 3, 0, 10);
    enable = 1'b1;
`ifndef FLOPPY_HOME_EN
    go(t2 + 100);
    home_req = 1'b1;
    go(t2 + 101);
    home_req = 1'b0;
`endif
    go(t2 + 411);
    rst_n = 1'b0;
    #1;
    chk("async_rst_step", int'(step), 0);
    chk("async_rst_track", int'(track), 0);
    go(t2 + 420);
    rst_n  = 1'b1;
    enable = 1'b0;
    go(t2 + 430);

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_steps: got %0d pulses outstanding, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
